// File: rtl/wb_trace_monitor.sv
// ---------------------------------------------------------------------------
// wb_trace_monitor
//
// Purpose:
//   Taps the CPU register-file write-back port. It records only the writes
//   that change the value of a watched register. Each record goes into a
//   first-word-fall-through FIFO with a cycle stamp. The block also detects
//   test completion through the done/pass register convention, and flags a
//   run-cycle timeout.
//
// Ports:
//   clk          : clock
//   rst          : asynchronous active-high reset
//   wb_en        : register-file write enable
//   wb_addr      : destination register index
//   wb_data      : write data (XLEN bits)
//   trc_valid    : FIFO head holds a record
//   trc_ready    : consumer accepts the head record
//   trc_addr     : head record register index
//   trc_data     : head record value
//   trc_cycle    : head record cycle stamp
//   fifo_level   : current FIFO occupancy
//   drop_cnt     : records lost to a full FIFO (saturating)
//   test_done    : DONE_REG was written with 1
//   test_pass    : PASS_REG shadow held 1 when done was reached
//   test_timeout : the cycle limit was reached before done
//
// FIFO_DEPTH must be a power of two and at least 2. The pointers rely on
// natural wrap-around at that size.
// ---------------------------------------------------------------------------
module wb_trace_monitor #(
    parameter int          XLEN           = 32,
    parameter logic [31:0] WATCH_MASK     = 32'h3800_0000,
    parameter int          FIFO_DEPTH     = 8,
    parameter int          TIMEOUT_CYCLES = 100000,
    parameter int          DONE_REG       = 26,
    parameter int          PASS_REG       = 27
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        wb_en,
    input  logic [4:0]                  wb_addr,
    input  logic [XLEN-1:0]             wb_data,
    output logic                        trc_valid,
    input  logic                        trc_ready,
    output logic [4:0]                  trc_addr,
    output logic [XLEN-1:0]             trc_data,
    output logic [31:0]                 trc_cycle,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic [15:0]                 drop_cnt,
    output logic                        test_done,
    output logic                        test_pass,
    output logic                        test_timeout
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic [1:0] {
        S_RUN,
        S_DONE,
        S_TIMEOUT
    } state_t;

    state_t            r_state;
    logic [31:0]       r_cyc;
    logic              r_done;
    logic              r_pass;
    logic              r_timeout;

    // Shadow copies of the register file. Only watched indices and PASS_REG
    // are ever written, so the remaining entries stay at their reset value.
    logic [XLEN-1:0]   r_shadow [32];

    logic [4:0]        r_memAddr  [FIFO_DEPTH];
    logic [XLEN-1:0]   r_memData  [FIFO_DEPTH];
    logic [31:0]       r_memCycle [FIFO_DEPTH];
    logic [AW-1:0]     r_wrPtr;
    logic [AW-1:0]     r_rdPtr;
    logic [LW-1:0]     r_level;
    logic              r_valid;
    logic [15:0]       r_drop;

    logic              w_run;
    logic              w_tracked;
    logic              w_shadowed;
    logic              w_capture;
    logic              w_doneHit;
    logic              w_timeoutHit;
    logic              w_pop;
    logic              w_full;
    logic              w_push;
    logic              w_drop;
    logic [LW-1:0]     w_levelNext;

    assign w_run        = (r_state == S_RUN);
    assign w_tracked    = (wb_addr != 5'd0) && WATCH_MASK[wb_addr];
    assign w_shadowed   = (wb_addr != 5'd0) &&
                          (WATCH_MASK[wb_addr] || (wb_addr == 5'(PASS_REG)));
    assign w_capture    = w_run && wb_en && w_tracked &&
                          (wb_data != r_shadow[wb_addr]);
    assign w_doneHit    = w_run && wb_en && (wb_addr == 5'(DONE_REG)) &&
                          (wb_data == XLEN'(1));
    assign w_timeoutHit = w_run && (TIMEOUT_CYCLES != 0) &&
                          (r_cyc == 32'(TIMEOUT_CYCLES));

    // A pop frees a slot in the same cycle, so a push into a full FIFO
    // is accepted when a pop happens alongside it.
    assign w_pop        = r_valid && trc_ready;
    assign w_full       = (r_level == LW'(FIFO_DEPTH));
    assign w_push       = w_capture && (!w_full || w_pop);
    assign w_drop       = w_capture && w_full && !w_pop;
    assign w_levelNext  = r_level + LW'(w_push) - LW'(w_pop);

    // Run/done/timeout FSM. The cycle counter advances only while the FSM
    // stays in RUN, so it is left frozen at its value in the transition cycle.
    // When done and timeout happen in the same cycle, done wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_RUN;
            r_cyc     <= 32'd0;
            r_done    <= 1'b0;
            r_pass    <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            case (r_state)
                S_RUN: begin
                    if (w_doneHit) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                        r_pass  <= (r_shadow[5'(PASS_REG)] == XLEN'(1));
                    end else if (w_timeoutHit) begin
                        r_state   <= S_TIMEOUT;
                        r_timeout <= 1'b1;
                    end else begin
                        r_cyc <= r_cyc + 32'd1;
                    end
                end
                default: begin
                    r_state <= r_state;
                end
            endcase
        end
    end

    // Shadow update. This happens whether or not the FIFO has room, so the
    // change detector always compares against the latest written value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                r_shadow[i] <= '0;
            end
        end else if (w_run && wb_en && w_shadowed) begin
            r_shadow[wb_addr] <= wb_data;
        end
    end

    // Trace FIFO. The head entry is presented directly from storage. That
    // entry is never overwritten while it is still unpopped, so the head
    // fields stay stable until the consumer takes them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_memAddr[i]  <= '0;
                r_memData[i]  <= '0;
                r_memCycle[i] <= '0;
            end
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_level <= '0;
            r_valid <= 1'b0;
            r_drop  <= 16'd0;
        end else begin
            if (w_push) begin
                r_memAddr[r_wrPtr]  <= wb_addr;
                r_memData[r_wrPtr]  <= wb_data;
                r_memCycle[r_wrPtr] <= r_cyc;
                r_wrPtr             <= r_wrPtr + AW'(1);
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + AW'(1);
            end
            r_level <= w_levelNext;
            r_valid <= (w_levelNext != '0);
            if (w_drop && (r_drop != 16'hFFFF)) begin
                r_drop <= r_drop + 16'd1;
            end
        end
    end

    assign trc_valid    = r_valid;
    assign trc_addr     = r_memAddr[r_rdPtr];
    assign trc_data     = r_memData[r_rdPtr];
    assign trc_cycle    = r_memCycle[r_rdPtr];
    assign fifo_level   = r_level;
    assign drop_cnt     = r_drop;
    assign test_done    = r_done;
    assign test_pass    = r_pass;
    assign test_timeout = r_timeout;

endmodule

// File: tb/tb_wb_trace_monitor.sv
// ---------------------------------------------------------------------------
// tb_wb_trace_monitor
//
// Purpose:
//   Self-checking bench for wb_trace_monitor. dut1 uses the default
//   parameters and is compared against a queue-based reference model.
//   dut2 sets TIMEOUT_CYCLES=20 and covers the timeout behaviour.
// ---------------------------------------------------------------------------
module tb_wb_trace_monitor;

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
        logic [31:0] cyc;
    } rec_t;

    localparam logic [31:0] MASK      = 32'h3800_0000;
    localparam int          DEPTH     = 8;
    localparam int          TIMEOUT1  = 100000;
    localparam int          DONE_IDX  = 26;
    localparam int          PASS_IDX  = 27;

    int checks = 0;
    int errors = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // dut1 signals
    logic        rst = 1'b1;
    logic        wbEn = 1'b0;
    logic [4:0]  wbAddr = 5'd0;
    logic [31:0] wbData = 32'd0;
    logic        trcReady = 1'b0;
    logic        trcValid;
    logic [4:0]  trcAddr;
    logic [31:0] trcData;
    logic [31:0] trcCycle;
    logic [3:0]  fifoLevel;
    logic [15:0] dropCnt;
    logic        testDone;
    logic        testPass;
    logic        testTimeout;

    // dut2 signals
    logic        rst2 = 1'b1;
    logic        wbEn2 = 1'b0;
    logic [4:0]  wbAddr2 = 5'd0;
    logic [31:0] wbData2 = 32'd0;
    logic        trcReady2 = 1'b0;
    logic        trcValid2;
    logic [4:0]  trcAddr2;
    logic [31:0] trcData2;
    logic [31:0] trcCycle2;
    logic [3:0]  fifoLevel2;
    logic [15:0] dropCnt2;
    logic        testDone2;
    logic        testPass2;
    logic        testTimeout2;

    wb_trace_monitor dut1 (
        .clk(clk), .rst(rst), .wb_en(wbEn), .wb_addr(wbAddr), .wb_data(wbData),
        .trc_valid(trcValid), .trc_ready(trcReady), .trc_addr(trcAddr),
        .trc_data(trcData), .trc_cycle(trcCycle), .fifo_level(fifoLevel),
        .drop_cnt(dropCnt), .test_done(testDone), .test_pass(testPass),
        .test_timeout(testTimeout)
    );

    wb_trace_monitor #(.TIMEOUT_CYCLES(20)) dut2 (
        .clk(clk), .rst(rst2), .wb_en(wbEn2), .wb_addr(wbAddr2), .wb_data(wbData2),
        .trc_valid(trcValid2), .trc_ready(trcReady2), .trc_addr(trcAddr2),
        .trc_data(trcData2), .trc_cycle(trcCycle2), .fifo_level(fifoLevel2),
        .drop_cnt(dropCnt2), .test_done(testDone2), .test_pass(testPass2),
        .test_timeout(testTimeout2)
    );

    // Reference model state for dut1
    rec_t        mQ [$];
    logic [31:0] mShadow [32];
    logic [31:0] mCyc;
    logic [15:0] mDrop;
    logic        mDone;
    logic        mPass;
    logic        mTimeout;

    // The model applies the rules directly. A record is captured when the
    // value changes, it is queued if there is room after this cycle's pop,
    // and it is counted as dropped otherwise.
    task automatic step1(input logic en, input logic [4:0] addr,
                         input logic [31:0] data, input logic ready);
        bit   pop;
        bit   cap;
        bit   running;
        bit   watched;
        rec_t r;
        @(negedge clk);
        wbEn = en; wbAddr = addr; wbData = data; trcReady = ready;
        running = !mDone && !mTimeout;
        watched = (addr != 0) && (((MASK >> addr) & 32'd1) != 0);
        pop     = (mQ.size() > 0) && ready;
        cap     = running && en && watched && (data != mShadow[addr]);
        if (running && en && addr == DONE_IDX && data == 1) begin
            mDone = 1'b1;
            mPass = (mShadow[PASS_IDX] == 1);
        end else if (running && TIMEOUT1 != 0 && mCyc == TIMEOUT1) begin
            mTimeout = 1'b1;
        end
        if (running && en && addr != 0 && (watched || addr == PASS_IDX))
            mShadow[addr] = data;
        if (pop) mQ.delete(0);
        if (cap) begin
            r.addr = addr; r.data = data; r.cyc = mCyc;
            if (mQ.size() < DEPTH) mQ.push_back(r);
            else if (mDrop != 16'hFFFF) mDrop = mDrop + 16'd1;
        end
        if (running && !mDone && !mTimeout) mCyc = mCyc + 32'd1;
        @(posedge clk);
        #1;
    endtask

    task automatic step2(input logic en, input logic [4:0] addr,
                         input logic [31:0] data, input logic ready);
        @(negedge clk);
        wbEn2 = en; wbAddr2 = addr; wbData2 = data; trcReady2 = ready;
        @(posedge clk);
        #1;
    endtask

    task automatic resetDut1();
        rst = 1'b1;
        wbEn = 1'b0; wbAddr = 5'd0; wbData = 32'd0; trcReady = 1'b0;
        mQ.delete();
        for (int i = 0; i < 32; i++) mShadow[i] = 32'd0;
        mCyc = 32'd0; mDrop = 16'd0; mDone = 1'b0; mPass = 1'b0; mTimeout = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
    endtask

    task automatic resetDut2();
        rst2 = 1'b1;
        wbEn2 = 1'b0; wbAddr2 = 5'd0; wbData2 = 32'd0; trcReady2 = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst2 = 1'b0;
    endtask

    task automatic test_timeout();
        resetDut2();
        for (int k = 0; k < 19; k++) step2(1'b0, 5'd0, 32'd0, 1'b0);
        step2(1'b1, 5'd27, 32'h13, 1'b0);
        checks++;
        if (testTimeout2 !== 1'b0) begin
            errors++; $display("[TB] FAIL timeout_early: got %0b expected 0", testTimeout2);
        end
        step2(1'b1, 5'd28, 32'h14, 1'b0);
        checks++;
        if ({testTimeout2, testDone2, testPass2} !== 3'b100) begin
            errors++; $display("[TB] FAIL timeout_rise: got t/d/p=%b expected 100",
                               {testTimeout2, testDone2, testPass2});
        end
        step2(1'b1, 5'd29, 32'h5, 1'b0);
        checks++;
        if (fifoLevel2 !== 4'd2) begin
            errors++; $display("[TB] FAIL timeout_level: got %0d expected 2", fifoLevel2);
        end
        checks++;
        if ({trcAddr2, trcData2, trcCycle2} !== {5'd27, 32'h13, 32'd19}) begin
            errors++; $display("[TB] FAIL timeout_head0: got %0d/%0h/%0d expected 27/13/19",
                               trcAddr2, trcData2, trcCycle2);
        end
        step2(1'b0, 5'd0, 32'd0, 1'b1);
        checks++;
        if ({trcAddr2, trcData2, trcCycle2} !== {5'd28, 32'h14, 32'd20}) begin
            errors++; $display("[TB] FAIL timeout_head1: got %0d/%0h/%0d expected 28/14/20",
                               trcAddr2, trcData2, trcCycle2);
        end
        step2(1'b0, 5'd0, 32'd0, 1'b1);
        checks++;
        if ({trcValid2, fifoLevel2, testTimeout2} !== {1'b0, 4'd0, 1'b1}) begin
            errors++; $display("[TB] FAIL timeout_drain: got v=%0b lvl=%0d t=%0b expected 0/0/1",
                               trcValid2, fifoLevel2, testTimeout2);
        end
    endtask

    task automatic test_done_wins();
        resetDut2();
        for (int k = 0; k < 20; k++) step2(1'b0, 5'd0, 32'd0, 1'b0);
        step2(1'b1, 5'd26, 32'd1, 1'b0);
        repeat (3) step2(1'b0, 5'd0, 32'd0, 1'b0);
        checks++;
        if ({testDone2, testTimeout2} !== 2'b10) begin
            errors++; $display("[TB] FAIL done_wins: got d/t=%b expected 10",
                               {testDone2, testTimeout2});
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #3;
        checks++;
        if ({trcValid, trcAddr, trcData, trcCycle, fifoLevel, dropCnt,
             testDone, testPass, testTimeout} !== '0) begin
            errors++; $display("[TB] FAIL reset_values: got v=%0b a=%0d d=%0h c=%0d l=%0d dr=%0d f=%b expected all 0",
                               trcValid, trcAddr, trcData, trcCycle, fifoLevel, dropCnt,
                               {testDone, testPass, testTimeout});
        end
        resetDut1();
    endtask

    task automatic test_change_only();
        resetDut1();
        step1(1'b1, 5'd27, 32'd5, 1'b0);
        step1(1'b1, 5'd27, 32'd5, 1'b0);
        step1(1'b1, 5'd28, 32'd7, 1'b0);
        checks++;
        if (fifoLevel !== 4'd2 || mQ.size() != 2) begin
            errors++; $display("[TB] FAIL change_level: got %0d expected 2", fifoLevel);
        end
        checks++;
        if ({trcAddr, trcData, trcCycle} !== {5'd27, 32'd5, 32'd0}) begin
            errors++; $display("[TB] FAIL change_rec0: got %0d/%0d/%0d expected 27/5/0",
                               trcAddr, trcData, trcCycle);
        end
        step1(1'b0, 5'd0, 32'd0, 1'b1);
        checks++;
        if ({trcValid, trcAddr, trcData, trcCycle} !== {1'b1, 5'd28, 32'd7, 32'd2}) begin
            errors++; $display("[TB] FAIL change_rec1: got v=%0b %0d/%0d/%0d expected 1 28/7/2",
                               trcValid, trcAddr, trcData, trcCycle);
        end
        step1(1'b0, 5'd0, 32'd0, 1'b1);
        checks++;
        if ({trcValid, fifoLevel} !== {1'b0, 4'd0}) begin
            errors++; $display("[TB] FAIL change_empty: got v=%0b lvl=%0d expected 0/0",
                               trcValid, fifoLevel);
        end
    endtask

    task automatic test_filtering();
        resetDut1();
        step1(1'b1, 5'd0, 32'd9, 1'b0);
        step1(1'b1, 5'd10, 32'd3, 1'b0);
        step1(1'b0, 5'd0, 32'd0, 1'b0);
        checks++;
        if ({trcValid, fifoLevel} !== {1'b0, 4'd0}) begin
            errors++; $display("[TB] FAIL filter: got v=%0b lvl=%0d expected 0/0",
                               trcValid, fifoLevel);
        end
    endtask

    task automatic test_overflow();
        resetDut1();
        for (int i = 0; i < 10; i++) step1(1'b1, 5'd29, 32'(100 + i), 1'b0);
        checks++;
        if ({fifoLevel, dropCnt} !== {4'd8, 16'd2}) begin
            errors++; $display("[TB] FAIL overflow_full: got lvl=%0d drop=%0d expected 8/2",
                               fifoLevel, dropCnt);
        end
        checks++;
        if ({trcAddr, trcData, trcCycle} !== {5'd29, 32'd100, 32'd0}) begin
            errors++; $display("[TB] FAIL overflow_head: got %0d/%0d/%0d expected 29/100/0",
                               trcAddr, trcData, trcCycle);
        end
        step1(1'b1, 5'd29, 32'd200, 1'b1);
        checks++;
        if ({fifoLevel, dropCnt, trcData, trcCycle} !== {4'd8, 16'd2, 32'd101, 32'd1}) begin
            errors++; $display("[TB] FAIL overflow_pushpop: got lvl=%0d drop=%0d head=%0d@%0d expected 8/2/101@1",
                               fifoLevel, dropCnt, trcData, trcCycle);
        end
    endtask

    task automatic test_pass();
        resetDut1();
        step1(1'b1, 5'd27, 32'd1, 1'b0);
        step1(1'b1, 5'd26, 32'd1, 1'b0);
        checks++;
        if ({testDone, testPass, testTimeout} !== 3'b110) begin
            errors++; $display("[TB] FAIL pass_flags: got d/p/t=%b expected 110",
                               {testDone, testPass, testTimeout});
        end
        step1(1'b1, 5'd27, 32'd2, 1'b0);
        step1(1'b1, 5'd28, 32'd3, 1'b0);
        checks++;
        if (fifoLevel !== 4'd1) begin
            errors++; $display("[TB] FAIL pass_nocapture: got lvl=%0d expected 1", fifoLevel);
        end
    endtask

    task automatic test_fail();
        resetDut1();
        step1(1'b1, 5'd27, 32'd3, 1'b0);
        step1(1'b1, 5'd27, 32'd0, 1'b0);
        step1(1'b1, 5'd26, 32'd1, 1'b0);
        checks++;
        if ({testDone, testPass, testTimeout} !== 3'b100) begin
            errors++; $display("[TB] FAIL fail_flags: got d/p/t=%b expected 100",
                               {testDone, testPass, testTimeout});
        end
    endtask

    task automatic test_random();
        logic [4:0]  addrTable [8];
        logic [4:0]  a;
        logic [31:0] d;
        logic        en;
        logic        rdy;
        addrTable[0] = 5'd0;  addrTable[1] = 5'd10; addrTable[2] = 5'd26;
        addrTable[3] = 5'd27; addrTable[4] = 5'd28; addrTable[5] = 5'd29;
        addrTable[6] = 5'd27; addrTable[7] = 5'd29;
        resetDut1();
        for (int k = 0; k < 313; k++) begin
            if (k < 300) begin
                en  = 1'($urandom_range(0, 3) != 0);
                a   = addrTable[$urandom_range(0, 7)];
                d   = 32'($urandom_range(0, 3));
                rdy = 1'($urandom_range(0, 2) == 0);
                if (a == 5'd26 && d == 32'd1) d = 32'd2;
            end else if (k == 300) begin
                en = 1'b1; a = 5'd26; d = 32'd1; rdy = 1'b0;
            end else begin
                en = 1'b1; a = 5'd28; d = 32'($urandom); rdy = 1'b1;
            end
            step1(en, a, d, rdy);
            checks++;
            if (trcValid !== (mQ.size() > 0) || fifoLevel !== 4'(mQ.size())) begin
                errors++; $display("[TB] FAIL rand_level k=%0d: got v=%0b lvl=%0d expected lvl=%0d",
                                   k, trcValid, fifoLevel, mQ.size());
            end
            checks++;
            if (dropCnt !== mDrop) begin
                errors++; $display("[TB] FAIL rand_drop k=%0d: got %0d expected %0d",
                                   k, dropCnt, mDrop);
            end
            if (mQ.size() > 0) begin
                checks++;
                if ({trcAddr, trcData, trcCycle} !== mQ[0]) begin
                    errors++; $display("[TB] FAIL rand_head k=%0d: got %0d/%0h/%0d expected %0d/%0h/%0d",
                                       k, trcAddr, trcData, trcCycle,
                                       mQ[0].addr, mQ[0].data, mQ[0].cyc);
                end
            end
            checks++;
            if ({testDone, testPass, testTimeout} !== {mDone, mPass, mTimeout}) begin
                errors++; $display("[TB] FAIL rand_flags k=%0d: got %b expected %b",
                                   k, {testDone, testPass, testTimeout},
                                   {mDone, mPass, mTimeout});
            end
        end
    endtask

    task automatic test_async_reset();
        resetDut1();
        step1(1'b1, 5'd27, 32'd1, 1'b0);
        step1(1'b1, 5'd28, 32'd2, 1'b0);
        step1(1'b1, 5'd29, 32'd3, 1'b0);
        checks++;
        if (fifoLevel !== 4'd3) begin
            errors++; $display("[TB] FAIL async_queued: got %0d expected 3", fifoLevel);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({trcValid, trcAddr, trcData, trcCycle, fifoLevel, dropCnt,
             testDone, testPass, testTimeout} !== '0) begin
            errors++; $display("[TB] FAIL async_reset: got v=%0b a=%0d d=%0h c=%0d l=%0d dr=%0d expected all 0",
                               trcValid, trcAddr, trcData, trcCycle, fifoLevel, dropCnt);
        end
        resetDut1();
    endtask

    initial begin
        test_timeout();
        test_done_wins();
        test_reset();
        test_change_only();
        test_filtering();
        test_overflow();
        test_pass();
        test_fail();
        test_random();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
